// File: rtl/lockstep_checker_pkg.sv
// lockstep_checker_pkg: shared state encoding and lag clamp helper for the
// lockstep comparator.
package lockstep_checker_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      CHECK = 2'd2,
      HALT  = 2'd3
   } lc_state_e;

   // Requested lags beyond the history depth are pinned to the deepest tap.
   function automatic int unsigned clamp_lag(input int unsigned lag,
                                             input int unsigned lag_max);
      return (lag > lag_max) ? lag_max : lag;
   endfunction

endpackage

// File: rtl/lockstep_hist.sv
// lockstep_hist: valid-gated shift register of past reference samples.
// tap returns the sample from 'sel' valid strobes ago; sel=0 passes din.
module lockstep_hist #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [DW-1:0]    din,
   input  logic [SEL_W-1:0] sel,
   output logic [DW-1:0]    tap
);

   logic [DEPTH-1:0][DW-1:0] mem;

   // Advance the history only on accepted samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem <= '0;
      end else if (valid) begin
         mem[0] <= din;
         for (int k = 1; k < DEPTH; k++) mem[k] <= mem[k-1];
      end
   end

   // Tap mux; loop form avoids a narrowed array index.
   always_comb begin
      tap = din;
      for (int k = 0; k < DEPTH; k++)
         if (sel == SEL_W'(k + 1)) tap = mem[k];
   end

endmodule

// File: rtl/lockstep_checker.sv
// lockstep_checker: compares stream b against stream a delayed by a
// programmable number of valid samples, with sticky failure reporting.
// Optional macro LOCKSTEP_CHECKER_ASSERT_EN adds a concurrent mismatch check.
module lockstep_checker
   import lockstep_checker_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int CHANNELS     = 2,
   parameter int LAG_MAX      = 4,
   parameter int CNT_W        = 8,
   parameter bit STOP_ON_FAIL = 1'b0,
   localparam int LAG_W       = $clog2(LAG_MAX + 1),
   localparam int DW          = WIDTH * CHANNELS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [LAG_W-1:0]    lag,
   input  logic                valid,
   input  logic [DW-1:0]       a,
   input  logic [DW-1:0]       b,
   output logic                busy,
   output logic                mismatch,
   output logic [CHANNELS-1:0] fail_ch,
   output logic [CNT_W-1:0]    err_cnt,
   output logic [DW-1:0]       first_a,
   output logic [DW-1:0]       first_b,
   output logic                halted
);

   lc_state_e           state;
   logic [LAG_W-1:0]    lag_q;
   logic [LAG_W-1:0]    warm;
   logic                first_seen;
   logic [LAG_W-1:0]    lag_in;
   logic [DW-1:0]       a_exp;
   logic [CHANNELS-1:0] diff;
   logic                record;

   assign lag_in = LAG_W'(clamp_lag(32'(lag), LAG_MAX));

   lockstep_hist #(.DW(DW), .DEPTH(LAG_MAX), .SEL_W(LAG_W)) u_hist (
      .clk   (clk),
      .rst   (rst),
      .valid (valid),
      .din   (a),
      .sel   (lag_q),
      .tap   (a_exp)
   );

   for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
      assign diff[i] = (a_exp[i*WIDTH +: WIDTH] != b[i*WIDTH +: WIDTH]);
   end

   assign record = (state == CHECK) && valid && (|diff);

   // Sequencer plus sticky result capture; all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         lag_q      <= '0;
         warm       <= '0;
         first_seen <= 1'b0;
         busy       <= 1'b0;
         mismatch   <= 1'b0;
         halted     <= 1'b0;
         fail_ch    <= '0;
         err_cnt    <= '0;
         first_a    <= '0;
         first_b    <= '0;
      end else begin
         mismatch <= 1'b0;
         // A failing sample is recorded even if en falls on the same edge.
         if (record) begin
            mismatch <= 1'b1;
            fail_ch  <= fail_ch | diff;
            if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            if (!first_seen) begin
               first_seen <= 1'b1;
               first_a    <= a_exp;
               first_b    <= b;
            end
         end
         case (state)
            IDLE: if (en) begin
               lag_q      <= lag_in;
               warm       <= '0;
               first_seen <= 1'b0;
               fail_ch    <= '0;
               err_cnt    <= '0;
               first_a    <= '0;
               first_b    <= '0;
               busy       <= 1'b1;
               state      <= (lag_in == '0) ? CHECK : ARM;
            end
            // Warm-up: the lag_q-th valid sample fills the tap but is not compared.
            ARM: if (!en) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else if (valid) begin
               warm <= warm + LAG_W'(1);
               if ((warm + LAG_W'(1)) == lag_q) state <= CHECK;
            end
            CHECK: if (!en) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else if (record && STOP_ON_FAIL) begin
               state  <= HALT;
               busy   <= 1'b0;
               halted <= 1'b1;
            end
            HALT: if (!en) begin
               state  <= IDLE;
               halted <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LOCKSTEP_CHECKER_ASSERT_EN
   int unsigned fail_idx;

   // Lowest differing channel, for the assertion message.
   always_comb begin
      fail_idx = 0;
      for (int i = CHANNELS - 1; i >= 0; i--)
         if (diff[i]) fail_idx = i;
   end

   a_lockstep_match: assert property (@(posedge clk) disable iff (rst)
      !(state == CHECK && valid && (|diff)))
      else $error("lockstep mismatch ch%0d expected=%h actual=%h", fail_idx,
                  a_exp[fail_idx*WIDTH +: WIDTH], b[fail_idx*WIDTH +: WIDTH]);
`endif

endmodule
